// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the operand-sequencer FSM encoding
// and key index constants used by the board front-end.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_XOR = 4'h3,
    ALU_SLL = 4'h4,
    ALU_SRL = 4'h5,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7
  } aluop_t;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_t;

  localparam int KEY_ENTER = 0;
  localparam int KEY_CLEAR = 3;
  localparam int NUM_KEYS  = 2;

  // Switch entry is a 17-bit two's-complement value; bit 16 is the sign.
  function automatic word_t sext_operand(input logic [16:0] v);
    return {{16{v[16]}}, v[15:0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low board key: 2-flop synchroniser, stability counter and
// a single-cycle press pulse on each accepted 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d   = sync2_q;
        press_d = lvl_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Released level is 1, so reset never produces a spurious press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Board front-end for the ALU: debounced enter/clear keys step operand A,
// operand B and op capture from the switches, then latch result and flags.
module alu_operand_sequencer
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  input  word_t       alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output word_t       porta,
  output word_t       portb,
  output aluop_t      aluop,
  output word_t       result,
  output logic [2:0]  flags,
  output logic        result_valid,
  output seq_state_t  state
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;
  logic                press_enter, press_clear;

  assign key_raw = {key_n[KEY_CLEAR], key_n[KEY_ENTER]};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .CLK  (CLK),
      .RST  (RST),
      .key_n(key_raw[g]),
      .press(press[g])
    );
  end

  assign press_enter = press[0];
  assign press_clear = press[1];

  logic unused_inputs;
  assign unused_inputs = ^{key_n[2:1], sw[17]};

  seq_state_t state_q, state_d;
  word_t      porta_q, porta_d;
  word_t      portb_q, portb_d;
  aluop_t     aluop_q, aluop_d;
  word_t      result_q, result_d;
  logic [2:0] flags_q, flags_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    porta_d  = porta_q;
    portb_d  = portb_q;
    aluop_d  = aluop_q;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
    if (press_clear) begin
      // Clear outranks a coincident enter, which is simply dropped.
      state_d  = S_A;
      porta_d  = '0;
      portb_d  = '0;
      aluop_d  = ALU_AND;
      result_d = '0;
      flags_d  = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_A: if (press_enter) begin
          porta_d = sext_operand(sw[16:0]);
          valid_d = 1'b0;
          state_d = S_B;
        end
        S_B: if (press_enter) begin
          portb_d = sext_operand(sw[16:0]);
          state_d = S_OP;
        end
        S_OP: if (press_enter) begin
          aluop_d = aluop_t'(sw[3:0]);
          state_d = S_EXEC;
        end
        // Operands have been stable on the ALU ports for a full cycle here.
        S_EXEC: begin
          result_d = alu_result;
          flags_d  = {alu_negative, alu_zero, alu_overflow};
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: if (press_enter) state_d = S_A;
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_A;
      porta_q  <= '0;
      portb_q  <= '0;
      aluop_q  <= ALU_AND;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      porta_q  <= porta_d;
      portb_q  <= portb_d;
      aluop_q  <= aluop_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign porta        = porta_q;
  assign portb        = portb_q;
  assign aluop        = aluop_q;
  assign result       = result_q;
  assign flags        = flags_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: key actions update a behavioural model of the operand
// sequencer; a monitor compares every visible output change in order.
module tb_alu_operand_sequencer;
  import cpu_types_pkg::*;

  localparam int DB = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] alu_result;
  logic        alu_negative, alu_zero, alu_overflow;
  logic [31:0] porta, portb, result;
  logic [3:0]  aluop;
  logic [2:0]  flags;
  logic        result_valid;
  logic [2:0]  state;

  always #5 CLK = ~CLK;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .key_n(key_n), .sw(sw),
    .alu_result(alu_result), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .porta(porta), .portb(portb), .aluop(aluop), .result(result),
    .flags(flags), .result_valid(result_valid), .state(state)
  );

  // Environment ALU: add, sub, otherwise bitwise and.
  function automatic logic [34:0] alu_f(input logic [31:0] a, b, input logic [3:0] op);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    if (op == 4'h2) begin
      r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 4'h6) begin
      r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]);
    end else r = a & b;
    return {r, r[31], (r == 32'd0), ov};
  endfunction

  always_comb begin
    {alu_result, alu_negative, alu_zero, alu_overflow} = alu_f(porta, portb, aluop);
  end

  int checks = 0;
  int errors = 0;

  // Model: state numbering 0=A 1=B 2=OP 3=EXEC 4=SHOW
  int          m_st;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic [2:0]  m_fl;
  logic        m_rv;
  logic [106:0] last_push;
  logic [106:0] exp_q[$];
  int           gap_q[$];

  function automatic logic [106:0] m_snap();
    return {3'(m_st), m_a, m_b, m_op, m_res, m_fl, m_rv};
  endfunction

  task automatic m_push(input int gap);
    if (m_snap() !== last_push) begin
      exp_q.push_back(m_snap());
      gap_q.push_back(gap);
      last_push = m_snap();
    end
  endtask

  task automatic m_clear();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_fl = 0; m_rv = 0;
  endtask

  task automatic m_enter(input logic [17:0] s);
    logic [34:0] r;
    logic [31:0] v;
    v = 32'(signed'(s[16:0]));
    case (m_st)
      0: begin m_a = v; m_rv = 0; m_st = 1; m_push(-1); end
      1: begin m_b = v; m_st = 2; m_push(-1); end
      2: begin
        m_op = s[3:0]; m_st = 3; m_push(-1);
        r = alu_f(m_a, m_b, m_op);
        m_res = r[34:3]; m_fl = r[2:0]; m_rv = 1; m_st = 4; m_push(1);
      end
      default: begin m_st = 0; m_push(-1); end
    endcase
  endtask

  // One key action: model first, then drive the keys and release them.
  task automatic press(input bit ent, input bit clr, input logic [17:0] s, input int hold);
    sw = s;
    if (clr) begin m_clear(); m_push(-1); end
    else if (ent) m_enter(s);
    key_n = 4'hF;
    key_n[0] = ~ent;
    key_n[3] = ~clr;
    repeat (hold) @(posedge CLK);
    key_n = 4'hF;
    repeat (DB + 8) @(posedge CLK);
  endtask

  task automatic glitch();
    key_n[0] = 1'b0;
    repeat (DB - 1) @(posedge CLK);
    key_n[0] = 1'b1;
    repeat (DB + 8) @(posedge CLK);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Monitor: any change on the output bundle consumes one expectation.
  logic [106:0] prev, cur, e;
  int cyc = 0, last_evt = 0, g;
  always @(negedge CLK) begin
    cur = {state, porta, portb, aluop, result, flags, result_valid};
    if (RST) prev = cur;
    else begin
      cyc++;
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change act=%h", cur);
        end else begin
          e = exp_q.pop_front();
          g = gap_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL snapshot act=%h req=%h", cur, e);
          end
          if (g >= 0) begin
            checks++;
            if (cyc - last_evt != g) begin
              errors++;
              $display("FAIL event_gap act=%0d req=%0d", cyc - last_evt, g);
            end
          end
        end
        last_evt = cyc;
        prev = cur;
      end
    end
  end

  initial begin
    int r, budget;
    logic [17:0] s;
    key_n = 4'hF; sw = '0; RST = 1'b1;
    m_clear(); last_push = m_snap();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_porta", porta, 32'd0);
    chk("rst_portb", portb, 32'd0);
    chk("rst_aluop", 32'(aluop), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags_valid", {28'd0, flags, result_valid}, 32'd0);

    press(1, 0, 18'h00005, DB + 4);
    press(1, 0, 18'h00003, DB + 4);
    press(1, 0, 18'h00002, DB + 4);
    #1;
    chk("add_porta", porta, 32'd5);
    chk("add_portb", portb, 32'd3);
    chk("add_aluop", 32'(aluop), 32'(ALU_ADD));
    chk("add_result", result, 32'd8);
    chk("add_flags", 32'(flags), 32'd0);
    chk("add_valid", 32'(result_valid), 32'd1);
    chk("add_state", 32'(state), 32'(S_SHOW));

    press(1, 0, 18'h00000, DB + 4);
    press(1, 0, 18'h10001, DB + 4);
    #1 chk("sext_porta", porta, 32'hFFFF0001);
    glitch();
    #1 chk("glitch_state", 32'(state), 32'(S_B));
    press(1, 0, 18'h00010, 200);
    #1 chk("hold_state", 32'(state), 32'(S_OP));

    press(0, 1, 18'h0, DB + 4);
    press(1, 0, 18'h00007, DB + 4);
    press(0, 1, 18'h0, DB + 4);
    #1 chk("clr_state", 32'(state), 32'(S_A));
    chk("clr_porta", porta, 32'd0);
    press(1, 0, 18'h00009, DB + 4);
    #1 chk("fresh_porta", porta, 32'd9);
    press(1, 0, 18'h00004, DB + 4);
    press(1, 1, 18'h00002, DB + 4);
    #1 chk("simul_state", 32'(state), 32'(S_A));
    chk("simul_valid", 32'(result_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      s = 18'($urandom);
      if (r < 2) s[3:0] = (r == 0) ? 4'h2 : 4'h6;
      if (r == 7) press(0, 1, s, DB + 2);
      else if (r == 8) glitch();
      else if (r == 9) press(1, 1, s, DB + 2);
      else press(1, 0, s, DB + 2 + $urandom_range(0, 6));
    end

    budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream front-end for the ALU on the FPGA board.
- Debounces the raw push-buttons and steps through a small state machine:
  - capture operand A from the switches;
  - capture operand B from the switches;
  - capture the ALU op from the switches;
  - execute and latch the ALU result and flags.
- Drives the ALU ports directly. Exposes the latched result and a valid flag to the downstream hex/LED display logic.

Parameters:
- DEBOUNCE_CYCLES, 500000: stable cycles required before a key level is accepted (10 ms at 50 MHz). Benches use 4.
- CNT_W, 20: width of each debounce counter. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- key_n  in  4  raw board keys, active-low, asynchronous to CLK. key_n[0]=enter, key_n[3]=clear, [2:1] unused.
- sw  in  18  raw board switches, treated as quasi-static. Sampled only on an enter pulse.
- alu_result  in  32 (word_t)  ALU combinational output
- alu_negative, alu_zero, alu_overflow  in  1 each  ALU flags
- porta  out  32 (word_t)  ALU operand A
- portb  out  32 (word_t)  ALU operand B
- aluop  out  4 (aluop_t)  ALU operation
- result  out  32 (word_t)  latched ALU result
- flags  out  3  latched {negative, zero, overflow}
- result_valid  out  1  result/flags hold a completed execution
- state  out  3 (seq_state_t)  current FSM state, for LEDs

Behaviour:
- Reset: all outputs go to 0, state=S_A, all debouncers go to released (level 1, counters 0).
  - RST asserted mid-operation aborts the operation in the same edge; no partial capture survives.
- Synchroniser: each key_n bit passes through 2 flops before use.
- Debounce, per key:
  - Counter clears whenever the synchronised level equals the accepted level.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A 1->0 flip of the accepted level produces a one-cycle press pulse.
  - Holding a key gives exactly one pulse; release gives none.
  - A glitch shorter than DEBOUNCE_CYCLES gives none.
- Latency: a clean key edge produces a pulse 2 (sync) + DEBOUNCE_CYCLES cycles later.
- Operand format: operands are {{16{sw[16]}}, sw[15:0]} (sign-extended 17-bit entry). aluop is aluop_t'(sw[3:0]).
- FSM, on press_enter:
  - S_A: porta <= operand; result_valid <= 0 -> S_B
  - S_B: portb <= operand -> S_OP
  - S_OP: aluop <= aluop_t'(sw[3:0]) -> S_EXEC
  - S_EXEC: ignores enter. Unconditionally latches result <= alu_result and flags, sets result_valid <= 1 -> S_SHOW.
    - This gives the combinational ALU one full cycle of settled inputs.
  - S_SHOW: porta/portb/aluop/result hold -> S_A on press_enter. Operand A is not captured on that press.
- press_clear in any state:
  - state <= S_A;
  - porta, portb, aluop, result, flags <= 0;
  - result_valid <= 0.
- Simultaneous press_clear and press_enter: clear wins; enter is dropped.
- Arithmetic: the block does none. Widths pass through unchanged. Undefined aluop encodings are passed to the ALU as-is.
- Combinational paths: no combinational path from any input to any output. All outputs are registered.

Decomposition:
- cpu_types_pkg: word_t and aluop_t are already present.
- Add to cpu_types_pkg:
  - seq_state_t: enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SHOW};
  - KEY_ENTER=0 and KEY_CLEAR=3 index constants.
- Sub-module key_debounce:
  - Parameters DEBOUNCE_CYCLES and CNT_W.
  - Ports CLK, RST, key_n (1 bit), press (1-cycle pulse). Includes the 2-flop synchroniser.
  - Instantiate it twice (enter, clear).

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert RST for 2 cycles with keys released -> all outputs 0, state=S_A, no press pulses for 20 cycles.
- Normal operation, A=5, B=3, op=ALU_ADD:
  - Press enter with sw[16:0]=0x00005, then 0x00003, then with sw[3:0]=ALU_ADD; bench ALU model returns porta+portb.
  - Required: porta=5, portb=3, aluop=ALU_ADD; result=8, flags zero=0, result_valid=1 exactly one cycle after S_EXEC; state=S_SHOW.
- Sign extension: sw[16]=1, sw[15:0]=0x0001, enter in S_A -> porta=0xFFFF0001.
- Bounce rejection:
  - key_n[0] low for 3 cycles then high -> no state change.
  - key_n[0] held low for 200 cycles -> exactly one transition.
- Clear mid-sequence: in S_B with porta=7, press clear -> state=S_A, porta=0, result_valid=0. Next enter captures A afresh.
- Simultaneous press in S_OP: both pulses in the same cycle -> state=S_A, aluop=0, no execution, result_valid=0.
